// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential signed divider.
// Q_MAX/Q_MIN bound the DW-bit two's-complement quotient range.
package div_pkg;

   localparam int DW = 19;
   localparam int VW = 8;
   localparam int CW = 5;

   localparam logic [DW-1:0] Q_MAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] Q_MIN = {1'b1, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX
   } state_t;

endpackage

// File: rtl/sgn_mag.sv
// Two's-complement conditional negate: y = neg ? -a : a.
// With neg tied to the sign bit it yields the unsigned magnitude.
module sgn_mag #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic         neg,
   output logic [W-1:0] y
);

   assign y = neg ? (W'(0) - a) : a;

endmodule

// File: rtl/div19s8s_seq.sv
// Iterative 19s / 8s restoring divider, sign-magnitude, start/busy/done.
// DIV19S8S_SAT_EN: saturate the quotient on -2^(DW-1) / -1 and flag ovf.
module div19s8s_seq #(
   parameter int DW = div_pkg::DW,
   parameter int VW = div_pkg::VW,
   parameter int CW = div_pkg::CW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] n1,
   input  logic [VW-1:0] n2,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          dbz,
   output logic          ovf
);

   import div_pkg::*;

   state_t        state;
   logic [DW-1:0] qr;
   logic [VW-1:0] dm;
   logic [VW-1:0] rem;
   logic [CW-1:0] cnt;
   logic          qsign;
   logic          rsign;
   logic          dbz_q;

   logic [DW-1:0] n1_mag;
   logic [VW-1:0] n2_mag;
   logic [DW-1:0] q_signed;
   logic [VW-1:0] r_signed;
   logic [VW:0]   rem_sh;
   logic [VW+1:0] trial;
   logic          q_bit;
   logic          ovf_hit;
   logic          unused;

   sgn_mag #(.W(DW)) u_mag1 (
      .a   (n1),
      .neg (n1[DW-1]),
      .y   (n1_mag)
   );

   sgn_mag #(.W(VW)) u_mag2 (
      .a   (n2),
      .neg (n2[VW-1]),
      .y   (n2_mag)
   );

   sgn_mag #(.W(DW)) u_qfix (
      .a   (qr),
      .neg (qsign),
      .y   (q_signed)
   );

   sgn_mag #(.W(VW)) u_rfix (
      .a   (rem),
      .neg (rsign),
      .y   (r_signed)
   );

   // Partial remainder stays below |n2| <= 2^(VW-1), so VW bits hold it.
   assign rem_sh = {rem, qr[DW-1]};
   assign trial  = {1'b0, rem_sh} - {2'b00, dm};
   assign q_bit  = ~trial[VW+1];
   assign unused = trial[VW];

   // A positive quotient with the top bit set only arises from MIN / -1.
   assign ovf_hit = ~qsign & qr[DW-1] & ~dbz_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         dbz       <= 1'b0;
         ovf       <= 1'b0;
         cnt       <= '0;
         qr        <= '0;
         dm        <= '0;
         rem       <= '0;
         qsign     <= 1'b0;
         rsign     <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  qr    <= n1_mag;
                  dm    <= n2_mag;
                  rem   <= '0;
                  qsign <= n1[DW-1] ^ n2[VW-1];
                  rsign <= n1[DW-1];
                  dbz_q <= (n2 == '0);
                  cnt   <= CW'(DW-1);
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               rem <= q_bit ? trial[VW-1:0] : rem_sh[VW-1:0];
               qr  <= {qr[DW-2:0], q_bit};
               if (cnt == '0) begin
                  state <= FIX;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            FIX: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               dbz   <= dbz_q;
               state <= IDLE;
               if (dbz_q) begin
                  quotient  <= '0;
                  remainder <= '0;
                  ovf       <= 1'b0;
               end else if (ovf_hit) begin
`ifdef DIV19S8S_SAT_EN
                  quotient  <= Q_MAX;
                  ovf       <= 1'b1;
`else
                  quotient  <= Q_MIN;
                  ovf       <= 1'b0;
`endif
                  remainder <= '0;
               end else begin
                  quotient  <= q_signed;
                  remainder <= r_signed;
                  ovf       <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
